vmicro16_apb_gpio_port: RTL and testbench
=========================================

Name: vmicro16_apb_gpio_port

Overview:
- APB completer that owns one GPIO bank: drives output pins, samples input pins, and raises an interrupt on input rising edges.
- Sits on the SoC peripheral bus behind the APB interconnect. It is the producing end of the gpio pins that benches check against expected values, e.g. gpio1 == 16'h7008 after a summation program.
- Read data is registered, so reads take one wait state. Writes complete with zero wait states.

Parameters:
- BUS_WIDTH, 16, APB data width.
- PINS, 16, number of GPIO pins; must be ≤ BUS_WIDTH.
- ADDR_WIDTH, 3, completer-local word address width.
- OUT_RESET, 0, reset value of the output register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- S_PADDR  in  ADDR_WIDTH  register word address
- S_PWRITE  in  1  1 = write, 0 = read
- S_PSELx  in  1  completer select
- S_PENABLE  in  1  APB access phase
- S_PWDATA  in  BUS_WIDTH  write data
- S_PRDATA  out  BUS_WIDTH  read data, valid while S_PREADY = 1
- S_PREADY  out  1  transfer complete
- gpio_out  out  PINS  output pin values
- gpio_in  in  PINS  asynchronous input pins
- irq  out  1  OR over (IS & IE)

Behaviour:
- Reset (asynchronous, active high):
  - gpio_out = OUT_RESET; IE = 0; IS = 0.
  - Input synchronisers and previous-sample register = 0.
  - S_PRDATA = 0; S_PREADY = 0; FSM = IDLE.
  - Reset asserted mid-transfer aborts it: no register update, S_PREADY low until a new SETUP phase.
- Register map (by S_PADDR):
  - 0 OUT: RW. Write sets gpio_out = PWDATA[PINS-1:0].
  - 1 SET: W. gpio_out |= PWDATA. Reads return 0.
  - 2 CLR: W. gpio_out &= ~PWDATA. Reads return 0.
  - 3 IN: RO. Returns the synchronised input.
  - 4 IE: RW. Interrupt enable mask.
  - 5 IS: rising-edge status. Writing 1 to a bit clears it.
  - 6–7: reads return 0; writes are ignored. Both still complete with S_PREADY (no error).
  - Bits above PINS read 0.
- Input path:
  - Two-flop synchroniser, then a previous-sample register.
  - rise = sync & ~prev. IS |= rise every cycle.
  - If a rise and a W1C hit the same bit in the same cycle, the set wins (IS bit stays 1).
- FSM states: IDLE, RD_WAIT, DONE.
  - IDLE, write access (PSELx & PENABLE & PWRITE):
    - S_PREADY = 1 combinationally in that cycle.
    - Register updates at that clock edge.
    - Next state = DONE.
  - IDLE, read access (PSELx & PENABLE & ~PWRITE):
    - S_PREADY = 0.
    - Latch the addressed register into S_PRDATA at the edge.
    - Next state = RD_WAIT.
  - RD_WAIT: S_PREADY = 1 and S_PRDATA holds the latched value. Next state = DONE.
  - DONE: S_PREADY = 0. Return to IDLE when PENABLE or PSELx is low; stay otherwise, so a held PENABLE never double-commits.
  - PSELx without PENABLE (setup phase) causes no state change.
- Latency and timing:
  - Write access phase is 1 cycle; new gpio_out is visible on the next cycle.
  - Read access phase is 2 cycles.
  - IN returns the pin value from 2 clocks before the sample; an edge appears in IS 3 clocks after the pin changes.
- Simultaneous events:
  - SET and CLR are separate transfers, so they never collide.
  - A read of IS in the same cycle as an edge returns the pre-update value.
- irq is registered: irq = |(IS & IE), updated every cycle.

Test Plan:
- Reset, then write OUT = 16'h7008 → gpio_out == 16'h7008 one cycle after S_PREADY; read OUT → S_PRDATA == 16'h7008 with S_PREADY high on the 2nd access cycle.
- OUT = 16'h00F0, SET 16'h0F0F, CLR 16'h0080 → gpio_out == 16'h0F7F; reads of SET and CLR return 0.
- Drive gpio_in = 16'h0005 → read IN returns 16'h0005 only once 2 clocks have elapsed; IS == 16'h0005 after 3 clocks; with IE = 16'h0004, irq rises; write IS = 16'h0004 → IS == 16'h0001 and irq = 0.
- Rising edge on bit 1 in the same cycle as a W1C of bit 1 → IS[1] remains 1.
- Assert reset during a read's RD_WAIT → S_PREADY = 0, S_PRDATA = 0, gpio_out = OUT_RESET; a subsequent read of OUT returns 0.
- Hold PSELx & PENABLE for 4 cycles on a SET write of 16'h0001 to gpio_out = 0 → exactly one S_PREADY pulse, gpio_out == 16'h0001; access to address 7 → S_PREADY with S_PRDATA == 0.

Source files
------------

// File: rtl/vmicro16_apb_gpio_port_if.sv
// rtl/vmicro16_apb_gpio_port_if.sv - APB completer-side bus bundle for the GPIO port
interface vmicro16_apb_gpio_port_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] S_PADDR;
    logic                  S_PWRITE;
    logic                  S_PSELx;
    logic                  S_PENABLE;
    logic [BUS_WIDTH-1:0]  S_PWDATA;
    logic [BUS_WIDTH-1:0]  S_PRDATA;
    logic                  S_PREADY;

    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        input  S_PRDATA, S_PREADY
    );

    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        output S_PRDATA, S_PREADY
    );
endinterface

// File: rtl/vmicro16_apb_gpio_port.sv
// rtl/vmicro16_apb_gpio_port.sv - APB GPIO bank with output set/clear and rising-edge interrupts
module vmicro16_apb_gpio_port #(
    parameter int              BUS_WIDTH  = 16,
    parameter int              PINS       = 16,
    parameter int              ADDR_WIDTH = 3,
    parameter logic [PINS-1:0] OUT_RESET  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    vmicro16_apb_gpio_port_if.slave apb,
    output logic [PINS-1:0]         gpio_out,
    input  logic [PINS-1:0]         gpio_in,
    output logic                    irq
);
    localparam logic [ADDR_WIDTH-1:0] A_OUT = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_SET = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CLR = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_IN  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_IE  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_IS  = ADDR_WIDTH'(5);

    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

    state_t              state, state_next;
    logic                wr_commit, rd_commit;
    logic [PINS-1:0]     sync1, sync2, prev;
    logic [PINS-1:0]     ie_reg, is_reg, is_next;
    logic [PINS-1:0]     wdata, rise, w1c;
    logic [BUS_WIDTH-1:0] rd_value;

    assign wdata = apb.S_PWDATA[PINS-1:0];
    assign rise  = sync2 & ~prev;
    assign w1c   = (wr_commit && apb.S_PADDR == A_IS) ? wdata : '0;
    // Rise is OR-ed in after the clear so a same-cycle edge survives a W1C.
    assign is_next = (is_reg & ~w1c) | rise;

    always_comb begin
        state_next   = state;
        wr_commit    = 1'b0;
        rd_commit    = 1'b0;
        apb.S_PREADY = 1'b0;
        case (state)
            IDLE: begin
                if (apb.S_PSELx && apb.S_PENABLE) begin
                    if (apb.S_PWRITE) begin
                        wr_commit    = 1'b1;
                        apb.S_PREADY = 1'b1;
                        state_next   = DONE;
                    end else begin
                        rd_commit  = 1'b1;
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                apb.S_PREADY = 1'b1;
                state_next   = DONE;
            end
            DONE: begin
                // Hold here while the access phase is still asserted to avoid a second commit.
                if (!(apb.S_PSELx && apb.S_PENABLE)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_value = '0;
        case (apb.S_PADDR)
            A_OUT:   rd_value[PINS-1:0] = gpio_out;
            A_IN:    rd_value[PINS-1:0] = sync2;
            A_IE:    rd_value[PINS-1:0] = ie_reg;
            A_IS:    rd_value[PINS-1:0] = is_reg;
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            gpio_out     <= OUT_RESET;
            ie_reg       <= '0;
            is_reg       <= '0;
            irq          <= 1'b0;
            apb.S_PRDATA <= '0;
        end else begin
            sync1  <= gpio_in;
            sync2  <= sync1;
            prev   <= sync2;
            is_reg <= is_next;
            irq    <= |(is_reg & ie_reg);
            if (wr_commit) begin
                case (apb.S_PADDR)
                    A_OUT:   gpio_out <= wdata;
                    A_SET:   gpio_out <= gpio_out | wdata;
                    A_CLR:   gpio_out <= gpio_out & ~wdata;
                    A_IE:    ie_reg   <= wdata;
                    default: ;
                endcase
            end
            if (rd_commit) apb.S_PRDATA <= rd_value;
        end
    end
endmodule

// File: tb/tb_vmicro16_apb_gpio_port.sv
// tb/tb_vmicro16_apb_gpio_port.sv - self-checking bench for vmicro16_apb_gpio_port
module tb_vmicro16_apb_gpio_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        irq;
    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] m_out, m_ie, m_is, m_in;

    vmicro16_apb_gpio_port_if #(.BUS_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    vmicro16_apb_gpio_port #(.BUS_WIDTH(16), .PINS(16), .ADDR_WIDTH(3), .OUT_RESET(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .apb      (bus),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Called and returns at posedge+1; checks the access-phase length (write 1, read 2).
    task automatic apb_xfer(input logic wr, input logic [2:0] a, input logic [15:0] d,
                            output logic [15:0] q);
        int   n;
        logic done;
        bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = wr;
        bus.S_PADDR = a;    bus.S_PWDATA = d;
        @(posedge clk); #1;
        bus.S_PENABLE = 1'b1;
        n = 0; done = 1'b0; q = '0;
        while (!done && n < 8) begin
            n++;
            @(negedge clk);
            if (bus.S_PREADY) begin done = 1'b1; q = bus.S_PRDATA; end
            @(posedge clk); #1;
        end
        bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0;
        vectors++;
        if (!done || n != (wr ? 1 : 2)) begin
            miscompares++;
            $display("FAIL access_cycles wr=%0d addr=%0d: got %0d (ready=%0d) want %0d", wr, a, n, done, wr ? 1 : 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; gpio_in = '0;
        bus.S_PSELx = 0; bus.S_PENABLE = 0; bus.S_PWRITE = 0; bus.S_PADDR = '0; bus.S_PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (gpio_out !== 16'h0 || irq !== 1'b0 || bus.S_PREADY !== 1'b0 || bus.S_PRDATA !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h irq=%b ready=%b prdata=%h want 0", gpio_out, irq, bus.S_PREADY, bus.S_PRDATA);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_out();
        logic [15:0] q;
        apb_xfer(1, 3'd0, 16'h7008, q);
        vectors++;
        if (gpio_out !== 16'h7008) begin miscompares++; $display("FAIL out_write: got %h want 7008", gpio_out); end
        apb_xfer(0, 3'd0, 16'h0, q);
        vectors++;
        if (q !== 16'h7008) begin miscompares++; $display("FAIL out_read: got %h want 7008", q); end
    endtask

    task automatic test_set_clr();
        logic [15:0] q;
        apb_xfer(1, 3'd0, 16'h00F0, q);
        apb_xfer(1, 3'd1, 16'h0F0F, q);
        vectors++;
        if (gpio_out !== 16'h0FFF) begin miscompares++; $display("FAIL set: got %h want 0fff", gpio_out); end
        apb_xfer(1, 3'd2, 16'h0080, q);
        vectors++;
        if (gpio_out !== 16'h0F7F) begin miscompares++; $display("FAIL clr: got %h want 0f7f", gpio_out); end
        apb_xfer(0, 3'd1, 16'h0, q);
        vectors++;
        if (q !== 16'h0) begin miscompares++; $display("FAIL set_read: got %h want 0", q); end
        apb_xfer(0, 3'd2, 16'h0, q);
        vectors++;
        if (q !== 16'h0) begin miscompares++; $display("FAIL clr_read: got %h want 0", q); end
    endtask

    task automatic test_in_irq();
        logic [15:0] q;
        apb_xfer(1, 3'd4, 16'h0004, q);
        gpio_in = 16'h0005;
        apb_xfer(0, 3'd3, 16'h0, q);
        vectors++;
        if (q !== 16'h0000) begin miscompares++; $display("FAIL in_too_early: got %h want 0000", q); end
        apb_xfer(0, 3'd5, 16'h0, q);
        vectors++;
        if (q !== 16'h0005) begin miscompares++; $display("FAIL is_edge: got %h want 0005", q); end
        apb_xfer(0, 3'd3, 16'h0, q);
        vectors++;
        if (q !== 16'h0005) begin miscompares++; $display("FAIL in_sync: got %h want 0005", q); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b want 1", irq); end
        apb_xfer(1, 3'd5, 16'h0004, q);
        apb_xfer(0, 3'd5, 16'h0, q);
        vectors++;
        if (q !== 16'h0001) begin miscompares++; $display("FAIL is_w1c: got %h want 0001", q); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_collision();
        logic [15:0] q;
        gpio_in = 16'h0007;
        @(posedge clk); #1;
        // Setup here puts the W1C commit on the same edge that records the bit-1 rise.
        apb_xfer(1, 3'd5, 16'h0002, q);
        apb_xfer(0, 3'd5, 16'h0, q);
        vectors++;
        if (q !== 16'h0003) begin miscompares++; $display("FAIL rise_beats_w1c: got %h want 0003", q); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] q;
        gpio_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        bus.S_PSELx = 1; bus.S_PENABLE = 0; bus.S_PWRITE = 0; bus.S_PADDR = 3'd0;
        @(posedge clk); #1;
        bus.S_PENABLE = 1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.S_PREADY !== 1'b0 || bus.S_PRDATA !== 16'h0 || gpio_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_in_rd_wait: ready=%b prdata=%h out=%h want 0/0000/0000", bus.S_PREADY, bus.S_PRDATA, gpio_out);
        end
        bus.S_PSELx = 0; bus.S_PENABLE = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        apb_xfer(0, 3'd0, 16'h0, q);
        vectors++;
        if (q !== 16'h0) begin miscompares++; $display("FAIL out_after_reset: got %h want 0000", q); end
    endtask

    task automatic test_held_enable();
        logic [15:0] q;
        int pulses;
        bus.S_PSELx = 1; bus.S_PENABLE = 0; bus.S_PWRITE = 1; bus.S_PADDR = 3'd1; bus.S_PWDATA = 16'h0001;
        @(posedge clk); #1;
        bus.S_PENABLE = 1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.S_PREADY) pulses++;
            @(posedge clk); #1;
        end
        bus.S_PSELx = 0; bus.S_PENABLE = 0;
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("FAIL held_pready_pulses: got %0d want 1", pulses); end
        vectors++;
        if (gpio_out !== 16'h0001) begin miscompares++; $display("FAIL held_set: got %h want 0001", gpio_out); end
        apb_xfer(1, 3'd7, 16'hFFFF, q);
        apb_xfer(0, 3'd7, 16'h0, q);
        vectors++;
        if (q !== 16'h0 || gpio_out !== 16'h0001) begin
            miscompares++;
            $display("FAIL addr7: prdata=%h out=%h want 0000/0001", q, gpio_out);
        end
    endtask

    task automatic test_random();
        logic [15:0] q, d, exp;
        logic [2:0]  a;
        m_out = 16'h0001; m_ie = 16'h0; m_is = 16'h0; m_in = 16'h0;
        for (int i = 0; i < 150; i++) begin
            d = 16'($urandom);
            a = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin
                    gpio_in = d;
                    repeat (4) @(posedge clk);
                    #1;
                    m_is = m_is | (d & ~m_in);
                    m_in = d;
                end
                1: begin
                    apb_xfer(1, a, d, q);
                    case (a)
                        3'd0: m_out = d;
                        3'd1: m_out = m_out | d;
                        3'd2: m_out = m_out & ~d;
                        3'd4: m_ie  = d;
                        3'd5: m_is  = m_is & ~d;
                        default: ;
                    endcase
                end
                default: begin
                    apb_xfer(0, a, 16'h0, q);
                    case (a)
                        3'd0: exp = m_out;
                        3'd3: exp = m_in;
                        3'd4: exp = m_ie;
                        3'd5: exp = m_is;
                        default: exp = 16'h0;
                    endcase
                    vectors++;
                    if (q !== exp) begin miscompares++; $display("FAIL rand_read addr=%0d: got %h want %h", a, q, exp); end
                end
            endcase
            @(posedge clk); #1;
            vectors++;
            if (gpio_out !== m_out || irq !== |(m_is & m_ie)) begin
                miscompares++;
                $display("FAIL rand_state: out=%h irq=%b want %h/%b", gpio_out, irq, m_out, |(m_is & m_ie));
            end
        end
    endtask

    initial begin
        test_reset();
        test_out();
        test_set_clr();
        test_in_irq();
        test_collision();
        test_reset_mid_read();
        test_held_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
